// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle 32-bit
// datapath. Instruction and data memory share one req/ready port.
// Outputs are decoded combinationally from the state register and from the
// opcode/func captured in DECODE. All outputs are held at 0 while rst_n is low.
//
// Build option ILLEGAL_TRAP_EN:
//   defined   - an illegal opcode/func parks the FSM in TRAP (trap=1) until reset
//   undefined - an illegal instruction retires as a NOP from DECODE; trap tied 0
module multicycle_ctrl #(
    parameter int ALUCTL_W = 4,
    parameter int OP_W     = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     Opcode,
    input  logic [OP_W-1:0]     Func,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                IorD,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCSrc,
    output logic                ALUSrc,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                instr_done,
    output logic                trap
);

    // Opcode field values
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);

    // R-type function field values
    localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'h20);
    localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'h22);
    localparam logic [OP_W-1:0] FN_AND = OP_W'(6'h24);
    localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'h25);
    localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'h2A);

    // ALUControl encodings
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(4'b0000);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(4'b0001);
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(4'b0010);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(4'b0110);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(4'b0111);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, fn_q;

    // Decode helpers -------------------------------------------------------

    function automatic logic func_legal(input logic [OP_W-1:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic instr_legal(input logic [OP_W-1:0] op,
                                         input logic [OP_W-1:0] fn);
        case (op)
            OP_RTYPE:                     return func_legal(fn);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [ALUCTL_W-1:0] func_alu(input logic [OP_W-1:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Class of the instruction captured in DECODE; only used from EXEC onward.
    logic is_r, is_lw, is_sw, is_beq;
    assign is_r   = (op_q == OP_RTYPE);
    assign is_lw  = (op_q == OP_LW);
    assign is_sw  = (op_q == OP_SW);
    assign is_beq = (op_q == OP_BEQ);

    // Legality is judged on the live IR fields during the DECODE cycle.
    logic dec_legal;
    assign dec_legal = instr_legal(Opcode, Func);

    // ALU setup chosen in EXEC and held through WB so ALUResult stays valid.
    logic [ALUCTL_W-1:0] ex_alu;
    logic                ex_alusrc;

    // ALU op / operand select for the latched instruction
    always_comb begin
        ex_alu    = ALU_ADD;
        ex_alusrc = 1'b1;
        if (is_r) begin
            ex_alu    = func_alu(fn_q);
            ex_alusrc = 1'b0;
        end else if (is_beq) begin
            ex_alu    = ALU_SUB;
            ex_alusrc = 1'b0;
        end
    end

    // State register; reset abandons whatever instruction was in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Capture opcode/func at the end of DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            fn_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= Opcode;
            fn_q <= Func;
        end
    end

    // Ungated strobe values, masked by rst_n at the ports
    logic                mem_req_c, iord_c, memwrite_c, irwrite_c, pcwrite_c;
    logic                pcsrc_c, alusrc_c, regdst_c, memtoreg_c, regwrite_c;
    logic                done_c;
    logic [ALUCTL_W-1:0] alu_c;
`ifdef ILLEGAL_TRAP_EN
    logic                trap_c;
`endif

    // Next-state and strobe decode
    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        pcsrc_c    = 1'b0;
        alusrc_c   = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alu_c      = '0;
        done_c     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap_c     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                // ALU computes PC+4 while the fetch is outstanding
                mem_req_c = 1'b1;
                alu_c     = ALU_ADD;
                if (mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    done_c  = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_c    = ex_alu;
                alusrc_c = ex_alusrc;
                if (is_beq) begin
                    pcsrc_c   = 1'b1;
                    pcwrite_c = Zero;
                    done_c    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Request fields stay constant until the memory accepts
                mem_req_c  = 1'b1;
                iord_c     = 1'b1;
                alusrc_c   = 1'b1;
                alu_c      = ALU_ADD;
                memwrite_c = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_c      = ex_alu;
                alusrc_c   = ex_alusrc;
                regwrite_c = 1'b1;
                regdst_c   = is_r;
                memtoreg_c = is_lw;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                trap_c  = 1'b1;
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Force every output low while reset is asserted
    assign mem_req    = rst_n & mem_req_c;
    assign IorD       = rst_n & iord_c;
    assign MemWrite   = rst_n & memwrite_c;
    assign IRWrite    = rst_n & irwrite_c;
    assign PCWrite    = rst_n & pcwrite_c;
    assign PCSrc      = rst_n & pcsrc_c;
    assign ALUSrc     = rst_n & alusrc_c;
    assign RegDst     = rst_n & regdst_c;
    assign MemtoReg   = rst_n & memtoreg_c;
    assign RegWrite   = rst_n & regwrite_c;
    assign ALUControl = rst_n ? alu_c : '0;
    assign instr_done = rst_n & done_c;
`ifdef ILLEGAL_TRAP_EN
    assign trap       = rst_n & trap_c;
`else
    assign trap       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl. A trace model expands each
// instruction into its expected per-cycle output vectors from the ISA rules
// (memory waits, branch outcome, legality), and the DUT is stepped against it.
module tb_multicycle_ctrl;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    logic       gclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = '0, Func = '0;
    logic       Zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrc;
    logic       RegDst, MemtoReg, RegWrite, instr_done, trap;
    logic [3:0] ALUControl;

    multicycle_ctrl #(.ALUCTL_W(4), .OP_W(6)) dut (
        .clk(gclk), .rst_n(rst_n), .Opcode(Opcode), .Func(Func), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .instr_done(instr_done), .trap(trap)
    );

    always #5 gclk = ~gclk;

    logic [15:0] obs;
    assign obs = {mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrc,
                  RegDst, MemtoReg, RegWrite, ALUControl, instr_done, trap};

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          rdy;
        bit          zero;
        logic [15:0] exp;
    } step_t;

    step_t tr[$];
    bit    trapped;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ov(input bit mr, iord, mw, irw, pcw, pcs, alus,
                                       rd, m2r, rw, input logic [3:0] alu,
                                       input bit done, trp);
        return {mr, iord, mw, irw, pcw, pcs, alus, rd, m2r, rw, alu, done, trp};
    endfunction

    function automatic bit m_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        return op inside {6'h23, 6'h2B, 6'h04, 6'h08};
    endfunction

    function automatic logic [3:0] m_ralu(input logic [5:0] fn);
        case (fn)
            6'h20:   return A_ADD;
            6'h22:   return A_SUB;
            6'h24:   return A_AND;
            6'h25:   return A_OR;
            default: return A_SLT;
        endcase
    endfunction

    // Expand one instruction into its cycle-by-cycle expected outputs.
    // fw/mw: wait cycles before mem_ready on fetch/data; zs<0 = random Zero.
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input int fw, input int mw, input int zs);
        step_t s;
        bit isr, lw, sw, beq, alus;
        logic [3:0] alu;
        tr.delete();
        trapped = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            s.rdy  = (i == fw);
            s.zero = 1'($urandom);
            s.exp  = ov(1, 0, 0, s.rdy, s.rdy, 0, 0, 0, 0, 0, A_ADD, 0, 0);
            tr.push_back(s);
        end
        s.rdy  = 1'($urandom);
        s.zero = 1'($urandom);
        if (!m_legal(op, fn)) begin
`ifdef ILLEGAL_TRAP_EN
            s.exp = '0;
            tr.push_back(s);
            for (int i = 0; i < 3; i++) begin
                s.rdy = 1'($urandom);
                s.exp = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
                tr.push_back(s);
            end
            trapped = 1'b1;
`else
            s.exp = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
            tr.push_back(s);
`endif
            return;
        end
        s.exp = '0;
        tr.push_back(s);
        isr  = (op == 6'h00);
        lw   = (op == 6'h23);
        sw   = (op == 6'h2B);
        beq  = (op == 6'h04);
        alu  = isr ? m_ralu(fn) : (beq ? A_SUB : A_ADD);
        alus = !(isr || beq);
        s.rdy  = 1'($urandom);
        s.zero = (zs < 0) ? 1'($urandom) : zs[0];
        if (beq) begin
            s.exp = ov(0, 0, 0, 0, s.zero, 1, 0, 0, 0, 0, A_SUB, 1, 0);
            tr.push_back(s);
            return;
        end
        s.exp = ov(0, 0, 0, 0, 0, 0, alus, 0, 0, 0, alu, 0, 0);
        tr.push_back(s);
        if (lw || sw) begin
            for (int i = 0; i <= mw; i++) begin
                s.rdy  = (i == mw);
                s.zero = 1'($urandom);
                s.exp  = ov(1, 1, sw, 0, 0, 0, 1, 0, 0, 0, A_ADD, sw && s.rdy, 0);
                tr.push_back(s);
            end
            if (sw) return;
        end
        s.rdy  = 1'($urandom);
        s.zero = 1'($urandom);
        s.exp  = ov(0, 0, 0, 0, 0, 0, alus, isr, lw, 1, alu, 1, 0);
        tr.push_back(s);
    endtask

    // Asynchronous reset pulse placed away from the rising edge; ends aligned
    // one time unit after a rising edge with the DUT in FETCH.
    task automatic pulse_reset(input string name);
        mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk({name, " rst_low"}, obs, '0);
        @(negedge gclk);
        chk({name, " rst_held"}, obs, '0);
        #1 rst_n = 1'b1;
        #1 chk({name, " rst_rel"}, obs, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0));
        @(posedge gclk);
        #1;
    endtask

    // Drive one instruction through the trace; cut>0 aborts with a reset
    // after that many cycles.
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input int fw, input int mw, input int zs, input int cut);
        build(op, fn, fw, mw, zs);
        Opcode = op;
        Func   = fn;
        foreach (tr[i]) begin
            mem_ready = tr[i].rdy;
            Zero      = tr[i].zero;
            @(negedge gclk);
            chk($sformatf("%s op=%h fn=%h c%0d", name, op, fn, i + 1), obs, tr[i].exp);
            if (cut > 0 && i + 1 == cut) begin
                pulse_reset(name);
                return;
            end
            @(posedge gclk);
            #1;
        end
        if (trapped) pulse_reset(name);
    endtask

    logic [5:0] rfn[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        logic [5:0] op, fn;
        int sel;
        // Reset state: everything low while rst_n is asserted
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge gclk);
            chk("reset", obs, '0);
        end
        #1 rst_n = 1'b1;
        #1 chk("post_reset", obs, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0));
        @(posedge gclk);
        #1;

        // Directed cases
        run("add",      6'h00, 6'h20, 0, 0, -1, 0);
        run("sub_fw2",  6'h00, 6'h22, 2, 0, -1, 0);
        run("slt",      6'h00, 6'h2A, 0, 0, -1, 0);
        run("lw_mw2",   6'h23, 6'h00, 0, 2, -1, 0);
        run("beq_z1",   6'h04, 6'h00, 0, 0,  1, 0);
        run("beq_z0",   6'h04, 6'h00, 0, 0,  0, 0);
        run("sw",       6'h2B, 6'h00, 0, 0, -1, 0);
        run("addi",     6'h08, 6'h11, 1, 0, -1, 0);
        run("sw_rst",   6'h2B, 6'h00, 0, 5, -1, 4);
        run("after_rst",6'h00, 6'h25, 0, 0, -1, 0);
        run("ill_op",   6'h3F, 6'h20, 0, 0, -1, 0);
        run("ill_fn",   6'h00, 6'h3F, 0, 0, -1, 0);
        run("and",      6'h00, 6'h24, 0, 0, -1, 0);

        // Random instruction mix with random memory latency
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            fn  = 6'($urandom);
            case (sel)
                0: begin op = 6'h00; fn = rfn[$urandom_range(0, 4)]; end
                1: op = 6'h00;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h08;
                6: op = 6'($urandom);
                default: op = 6'h3F;
            endcase
            run("rnd", op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
